// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Transaction owner encoding
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  // Legal memory read latency range (4-bit down-counter)
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory bus bundle for mem_port_arbiter.
// Handshake: a requester raises req with we/addr/wdata and holds req until
// it sees a one-cycle ack; read data is valid in the ack cycle and stays
// stable until that requester's next read. Fields are sampled only when
// the arbiter is idle. stall = req & ~ack. mem_en is a single-cycle strobe,
// and mem_rdata must be valid MEM_LAT cycles after the mem_en cycle.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_ack, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_ack, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection between CPU and loader.
// ARB_FAIR_EN defined: round-robin on ties; undefined: CPU has fixed priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   ldr_req_i,
  input  owner_e last_owner_i,
  output logic   grant_valid_o,
  output owner_e grant_owner_o
);

`ifndef ARB_FAIR_EN
  // Last owner only matters for round-robin
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
`endif

  // Pick a winner; a lone requester always wins
  always_comb begin
    grant_valid_o = cpu_req_i | ldr_req_i;
`ifdef ARB_FAIR_EN
    if (cpu_req_i && ldr_req_i) begin
      grant_owner_o = (last_owner_i == OWN_CPU) ? OWN_LDR : OWN_CPU;
    end else if (cpu_req_i) begin
      grant_owner_o = OWN_CPU;
    end else begin
      grant_owner_o = OWN_LDR;
    end
`else
    grant_owner_o = cpu_req_i ? OWN_CPU : OWN_LDR;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified I/D memory arbiter for the multicycle MIPS core: CPU control
// path vs. program loader. One transaction in flight, one-cycle ack.
// Optional macro ARB_FAIR_EN selects round-robin arbitration (see arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  mem_port_arbiter_if.slave   bus,
  output state_e              dbg_state_o
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT out of range 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]  ldr_rdata_q, ldr_rdata_d;

  logic               grant_valid;
  owner_e             grant_owner;
  logic               cpu_ack, ldr_ack, mem_en, mem_we;

  arb_pick u_arb_pick (
    .cpu_req_i     (bus.cpu_req),
    .ldr_req_i     (bus.ldr_req),
    .last_owner_i  (owner_q),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_LDR;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Next state: latch the winner's fields in IDLE, count read latency in WAIT
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          if (grant_owner == OWN_CPU) begin
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end else begin
            we_d    = bus.ldr_we;
            addr_d  = bus.ldr_addr;
            wdata_d = bus.ldr_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_CPU) cpu_rdata_d = bus.mem_rdata;
          else                    ldr_rdata_d = bus.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    mem_en  = (state_q == ISSUE);
    mem_we  = (state_q == ISSUE) && we_q;
    cpu_ack = (state_q == DONE) && (owner_q == OWN_CPU);
    ldr_ack = (state_q == DONE) && (owner_q == OWN_LDR);
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.ldr_ack   = ldr_ack;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ldr_rdata = ldr_rdata_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a MEM_LAT=3 memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int MEM_LAT = 3;

  logic   Clk;
  logic   Reset;
  state_e dbg_state;
  int     n_chk;
  int     n_bad;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // memory model: writes on mem_en&mem_we, reads return data MEM_LAT cycles later
  logic [31:0] mem  [0:63];
  logic [31:0] pipe [0:MEM_LAT-1];

  always_ff @(posedge Clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:2]] : 32'hBAD0_BAD0;
    for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.mem_rdata = pipe[MEM_LAT-1];

  // checker
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // driver helpers: inputs change just after posedge, checks at negedge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  task automatic idle_reqs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
  endtask

  // one request from a single requester; checks ack latency, then drops req
  task automatic run_req(input bit is_ldr, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int exp_cyc, input string tag);
    int got;
    bit other;
    tick();
    if (is_ldr) begin
      bus.ldr_req = 1'b1; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wdata;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
    got   = -1;
    other = 1'b0;
    for (int i = 0; i < 24; i++) begin
      smp();
      if (is_ldr ? bus.cpu_ack : bus.ldr_ack) other = 1'b1;
      if (is_ldr ? bus.ldr_ack : bus.cpu_ack) begin
        got = i;
        break;
      end
      tick();
    end
    chk({tag, "_ack_cycle"}, 64'(got), 64'(exp_cyc));
    chk({tag, "_other_ack"}, 64'(other), 64'd0);
    tick();
    idle_reqs();
  endtask

  int exp_owner;
  int got_owner;

  initial begin
    n_chk = 0;
    n_bad = 0;
    idle_reqs();
    Reset = 1'b0;

    // reset state
    smp(); smp();
    chk("rst_state",     64'(dbg_state),     64'(IDLE));
    chk("rst_cpu_ack",   64'(bus.cpu_ack),   64'd0);
    chk("rst_ldr_ack",   64'(bus.ldr_ack),   64'd0);
    chk("rst_mem_en",    64'(bus.mem_en),    64'd0);
    chk("rst_mem_we",    64'(bus.mem_we),    64'd0);
    chk("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
    chk("rst_ldr_rdata", 64'(bus.ldr_rdata), 64'd0);
    tick();
    Reset = 1'b1;

    // loader-only write: single requester wins in either mode
    run_req(1'b1, 1'b1, 32'h30, 32'h0000_1234, 2, "ldr_wr");
    chk("ldr_wr_mem", 64'(mem[12]), 64'h1234);

    // CPU write 0x10 / 0xDEADBEEF, cycle by cycle
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEAD_BEEF;
    smp();
    chk("wr_c0_mem_en", 64'(bus.mem_en),    64'd0);
    chk("wr_c0_stall",  64'(bus.cpu_stall), 64'd1);
    tick(); smp();
    chk("wr_c1_mem_en", 64'(bus.mem_en),    64'd1);
    chk("wr_c1_mem_we", 64'(bus.mem_we),    64'd1);
    chk("wr_c1_addr",   64'(bus.mem_addr),  64'h10);
    chk("wr_c1_wdata",  64'(bus.mem_wdata), 64'hDEAD_BEEF);
    chk("wr_c1_ack",    64'(bus.cpu_ack),   64'd0);
    tick(); smp();
    chk("wr_c2_cpu_ack", 64'(bus.cpu_ack),   64'd1);
    chk("wr_c2_ldr_ack", 64'(bus.ldr_ack),   64'd0);
    chk("wr_c2_stall",   64'(bus.cpu_stall), 64'd0);
    chk("wr_c2_mem_en",  64'(bus.mem_en),    64'd0);
    tick();
    idle_reqs();

    // CPU read 0x30 with MEM_LAT=3: ack in cycle 5
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h30;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      smp();
      chk($sformatf("rd_c%0d_stall", c),  64'(bus.cpu_stall), 64'(c < 5));
      chk($sformatf("rd_c%0d_mem_en", c), 64'(bus.mem_en),    64'(c == 1));
      chk($sformatf("rd_c%0d_ack", c),    64'(bus.cpu_ack),   64'(c == 5));
    end
    chk("rd_rdata",     64'(bus.cpu_rdata), 64'h1234);
    chk("rd_ldr_rdata", 64'(bus.ldr_rdata), 64'd0);
    tick();
    idle_reqs();

    // address changed after the grant has no effect
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'hA5A5_0001;
    smp();
    tick();
    bus.cpu_addr = 32'h40;
    smp();
    chk("late_addr_mem_addr", 64'(bus.mem_addr), 64'h20);
    tick(); smp();
    chk("late_addr_ack",  64'(bus.cpu_ack), 64'd1);
    tick();
    idle_reqs();
    chk("late_addr_mem",   64'(mem[8]),       64'hA5A5_0001);
    chk("wr_keeps_rdata",  64'(bus.cpu_rdata), 64'h1234);

    // reset during WAIT aborts the loader read
    tick();
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 32'h30;
    smp();
    tick(); smp();
    tick();
    chk("mid_pre_state", 64'(dbg_state), 64'(WAIT));
    Reset = 1'b0;
    idle_reqs();
    #1;
    chk("mid_mem_en_now", 64'(bus.mem_en), 64'd0);
    smp();
    chk("mid_state",     64'(dbg_state),     64'(IDLE));
    chk("mid_ldr_ack",   64'(bus.ldr_ack),   64'd0);
    chk("mid_cpu_ack",   64'(bus.cpu_ack),   64'd0);
    chk("mid_mem_addr",  64'(bus.mem_addr),  64'd0);
    chk("mid_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
    chk("mid_ldr_rdata", 64'(bus.ldr_rdata), 64'd0);
    tick();
    Reset = 1'b1;
    got_owner = 0;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (bus.ldr_ack || bus.cpu_ack || bus.mem_en) got_owner = 1;
      tick();
    end
    chk("mid_no_late_ack", 64'(got_owner), 64'd0);
    run_req(1'b0, 1'b0, 32'h10, 32'h0, 2 + MEM_LAT, "post_rst_rd");
    chk("post_rst_rdata", 64'(bus.cpu_rdata), 64'hDEAD_BEEF);

    // both requesters held for 4 transactions from a fresh reset
    tick(); Reset = 1'b0;
    tick(); Reset = 1'b1;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h00; bus.cpu_wdata = 32'h1;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 32'h04; bus.ldr_wdata = 32'h2;
    for (int t = 0; t < 4; t++) begin
      got_owner = -1;
      for (int i = 0; i < 12; i++) begin
        smp();
        if (bus.cpu_ack || bus.ldr_ack) begin
          got_owner = (bus.cpu_ack && bus.ldr_ack) ? 3 : (bus.ldr_ack ? 1 : 0);
          tick();
          break;
        end
        tick();
      end
`ifdef ARB_FAIR_EN
      exp_owner = t % 2;
`else
      exp_owner = 0;
`endif
      chk($sformatf("tie_owner_%0d", t), 64'(got_owner), 64'(exp_owner));
    end
    idle_reqs();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU control path (fetch, lw, sw) and the program loader/debug port. Each accepted request becomes exactly one memory transaction. The arbiter returns a one-cycle ack, plus read data for reads, to the winner. It also drives a stall to the controller so that the controller's state machine holds while the loader owns memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles (legal 1..15)

- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata  same directions, widths and meanings as the cpu_* ports, for the loader
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  valid MEM_LAT cycles after the mem_en cycle

## Operation
- FSM states: IDLE → ISSUE → (write) DONE → IDLE; IDLE → ISSUE → (read) WAIT → DONE → IDLE.
- IDLE:
  - Sample both requests.
  - If any request is active, pick a winner and register the owner, addr, we and wdata.
  - Go to ISSUE.
- ISSUE: drive mem_en=1 and mem_we=latched we for exactly one cycle.
- WAIT:
  - Down-counter (4 bits) loaded with MEM_LAT-1.
  - When the count reaches 0, capture mem_rdata into the owner's rdata register, then go to DONE.
- DONE: pulse the owner's ack for one cycle. The other requester's ack stays 0.
- The request fields are latched in IDLE, so requester changes after the grant have no effect.
- Dropping req before ack is a protocol violation. The transaction still completes and the ack still pulses.
- A req still high in the IDLE cycle after ack is treated as a new request.
- Writes do not modify either rdata register.
- Reset values: state IDLE, all acks 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, both rdata 0, owner = LDR.
- Reset asserted mid-transaction aborts it; no ack is issued and mem_en drops immediately.

## Timing
- Request seen in IDLE at cycle 0 → mem_en in cycle 1.
- Write: ack in cycle 2.
- Read: ack in cycle 2+MEM_LAT, with rdata stable from the ack cycle until the next read by the same requester.
- Back-to-back throughput: one write per 3 cycles; one read per 3+MEM_LAT cycles.
- mem_en is never asserted in two consecutive cycles.
- At most one transaction is in flight at any time.

## Configuration
- ARB_FAIR_EN defined: round-robin.
  - When both requesters are active in IDLE, the one that did not own the previous transaction wins.
  - The owner resets to LDR, so the CPU wins the first tie.
- ARB_FAIR_EN undefined: fixed priority. The CPU always wins a tie, and the loader is served only when cpu_req=0 in IDLE.
- With a single active requester, that requester wins in both modes.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE)
  - owner encoding (OWN_CPU=0, OWN_LDR=1)
  - MEM_LAT legal-range constants
- Sub-module arb_pick (combinational):
  - Inputs: cpu_req, ldr_req, last owner.
  - Outputs: grant_valid, grant_owner.
  - Contains the only ARB_FAIR_EN-dependent logic.
- Top level holds the FSM, latency counter, latches and output registers.

## Test plan
- Reset mid-read (Reset low during WAIT) → no ack, mem_en=0, all outputs at their reset values; the next cpu_req completes normally.
- CPU write only, addr 0x10, data 0xDEADBEEF → mem_en=1 and mem_we=1 in cycle 1 with that addr and data; cpu_ack in cycle 2; ldr_ack stays 0.
- CPU read with MEM_LAT=3, memory returns 0x1234 → mem_en in cycle 1; cpu_ack in cycle 5 with cpu_rdata=0x1234; cpu_stall high in cycles 0–4 and low in cycle 5.
- Both requesters held high for 4 transactions:
  - ARB_FAIR_EN defined → owners CPU, LDR, CPU, LDR.
  - ARB_FAIR_EN undefined → CPU, CPU, CPU, CPU, with ldr_ack never asserted.
- cpu_addr changed from 0x20 to 0x40 in cycle 1 (after the grant) → mem_addr=0x20; ack still issued.
